// File: rtl/rca_seq_ctrl_if.sv
// Request/result handshake bundle for the multi-precision add/subtract sequencer.
// The master is the requesting datapath; the slave is the sequencer.
interface rca_seq_ctrl_if #(
  parameter int SIZE  = 4,
  parameter int WORDS = 4
);
  localparam int W = SIZE * WORDS;

  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         req_cin;
  logic         req_sub;

  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_sum;
  logic         res_cout;
  logic         res_ovf;

  modport master (
    output req_valid, req_a, req_b, req_cin, req_sub, res_ready,
    input  req_ready, res_valid, res_sum, res_cout, res_ovf
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, req_sub, res_ready,
    output req_ready, res_valid, res_sum, res_cout, res_ovf
  );
endinterface

// File: rtl/rca_seq_ctrl.sv
// Multi-precision add/subtract sequencer. Walks one external SIZE-bit ripple
// carry adder slice across WORDS cycles, LSB slice first, carrying between
// slices through a register so the adder remains a pure combinational block.
module rca_seq_ctrl #(
  parameter int SIZE  = 4,
  parameter int WORDS = 4
) (
  input  logic            clk,
  input  logic            rst,
  rca_seq_ctrl_if.slave   bus,
  output logic            busy,
  output logic [SIZE-1:0] add_a,
  output logic [SIZE-1:0] add_b,
  output logic            add_cin,
  input  logic [SIZE-1:0] add_s,
  input  logic            add_cout
);

  localparam int W  = SIZE * WORDS;
  // Keep the index at least one bit wide so WORDS=1 still elaborates.
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_reg;
  logic [IW-1:0]   idx_reg;
  logic            carry_reg;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;      // already inverted for subtract
  logic [W-1:0]    sum_reg;
  logic            cout_reg;
  logic            ovf_reg;
  logic            req_ready_reg;
  logic            res_valid_reg;
  logic            busy_reg;

  // Slice views of the captured operands, indexed by the running slice number.
  logic [SIZE-1:0] a_words [WORDS];
  logic [SIZE-1:0] b_words [WORDS];

  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_slice
      assign a_words[gi] = a_reg[gi*SIZE +: SIZE];
      assign b_words[gi] = b_reg[gi*SIZE +: SIZE];
    end
  endgenerate

  // Present the current slice to the adder only while running; zero otherwise.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state_reg == RUN) begin
      add_a   = a_words[idx_reg];
      add_b   = b_words[idx_reg];
      add_cin = carry_reg;
    end
  end

  // Sequencer FSM: capture, ripple slice by slice, then hold the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      carry_reg     <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      sum_reg       <= '0;
      cout_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
      req_ready_reg <= 1'b1;
      res_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.req_valid) begin
            a_reg         <= bus.req_a;
            b_reg         <= bus.req_sub ? ~bus.req_b : bus.req_b;
            // Subtract is A + ~B + 1, so the caller's carry-in is dropped.
            carry_reg     <= bus.req_sub ? 1'b1 : bus.req_cin;
            idx_reg       <= '0;
            cout_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
            req_ready_reg <= 1'b0;
            busy_reg      <= 1'b1;
            state_reg     <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < WORDS; i++) begin
            if (idx_reg == IW'(i)) sum_reg[i*SIZE +: SIZE] <= add_s;
          end
          carry_reg <= add_cout;
          if (idx_reg == IW'(WORDS - 1)) begin
            // The MSB slice sum arrives now, so overflow is resolved on this edge.
            cout_reg      <= add_cout;
            ovf_reg       <= (a_reg[W-1] == b_reg[W-1]) &&
                             (add_s[SIZE-1] != a_reg[W-1]);
            res_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            res_valid_reg <= 1'b0;
            req_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
            idx_reg       <= '0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          req_ready_reg <= 1'b1;
          res_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_reg;
  assign bus.res_valid = res_valid_reg;
  assign bus.res_sum   = sum_reg;
  assign bus.res_cout  = cout_reg;
  assign bus.res_ovf   = ovf_reg;
  assign busy          = busy_reg;

endmodule
